// File: rtl/shift_tx_pkg.sv
// Shared definitions for the shift_tx serializer.
// Holds the controller state encoding and the default frame geometry
// (bits per frame and clk cycles per sclk half-period) used by the
// top level and the half-period tick generator.
package shift_tx_pkg;

  localparam int DEFAULT_WIDTH   = 24;
  localparam int DEFAULT_CLK_DIV = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/shift_tx_sclk_tick.sv
// sclk_tick_gen: half-period timer for the shift clock.
// Counts clk cycles while enabled and raises tick for one cycle on the
// last cycle of every CLK_DIV-cycle half-period. clear restarts the count
// so each frame begins on a half-period boundary.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   clear      - restart the half-period count (frame start)
//   enable     - count while high (frame in progress)
//   tick       - one-cycle pulse at the end of each half-period
module sclk_tick_gen
  import shift_tx_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST_CNT) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_tx.sv
// shift_tx: parallel-to-serial transmitter for an external shift-register
// chain (595-style). A word accepted on valid && ready is shifted out MSB
// first on sdo with a generated sclk, followed by a latch strobe.
// Every bit lasts 2*CLK_DIV clk cycles (sclk low then high) and the latch
// phase lasts another 2*CLK_DIV cycles, so a frame is (WIDTH+1)*2*CLK_DIV
// cycles long after the accept cycle.
// Ports:
//   clk, rst_n - system clock, asynchronous active-low reset
//   data_in    - word to serialize
//   valid      - send request, honoured only while ready
//   ready      - high in IDLE only
//   sdo        - serial data, stable for the whole bit period
//   sclk       - chain shift clock (chain samples on rising edge)
//   latch      - chain storage strobe (outputs update on rising edge)
// Optional build macro SHIFT_TX_AUTO_REFRESH_EN: keep the last accepted
// word and resend it whenever an IDLE cycle passes without valid.
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             sdo,
  output logic             sclk,
  output logic             latch
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             phase_q, phase_d;
  logic             sclk_q, sclk_d;
  logic             latch_q, latch_d;
  logic             start;
  logic [WIDTH-1:0] start_word;
  logic             tick;

`ifdef SHIFT_TX_AUTO_REFRESH_EN
  logic [WIDTH-1:0] last_q, last_d;
  logic             have_q, have_d;

  // A fresh request always wins; otherwise an idle cycle replays the
  // retained word, but only once a word has actually been accepted.
  assign start      = (state_q == IDLE) && (valid || have_q);
  assign start_word = valid ? data_in : last_q;

  always_comb begin
    last_d = last_q;
    have_d = have_q;
    if ((state_q == IDLE) && valid) begin
      last_d = data_in;
      have_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      have_q <= 1'b0;
    end else begin
      last_q <= last_d;
      have_q <= have_d;
    end
  end
`else
  assign start      = (state_q == IDLE) && valid;
  assign start_word = data_in;
`endif

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .enable(state_q != IDLE),
    .tick  (tick)
  );

  assign ready = (state_q == IDLE);
  // The shift register is only advanced at bit boundaries, so its MSB is
  // the current bit and stays put in IDLE as the last bit sent.
  assign sdo   = shreg_q[WIDTH-1];
  assign sclk  = sclk_q;
  assign latch = latch_q;

  // phase_q selects the half of the current period: in SHIFT the sclk-low
  // or sclk-high half of a bit, in LATCH the strobe-high or strobe-low half.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    sclk_d    = sclk_q;
    latch_d   = latch_q;
    unique case (state_q)
      IDLE: begin
        sclk_d    = 1'b0;
        latch_d   = 1'b0;
        phase_d   = 1'b0;
        bit_cnt_d = '0;
        if (start) begin
          shreg_d = start_word;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            sclk_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            sclk_d  = 1'b0;
            phase_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              latch_d   = 1'b1;
              state_d   = LATCH;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          if (!phase_q) begin
            latch_d = 1'b0;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All chain-facing strobes come straight from flops cleared by reset, so
  // reset entry and exit cannot glitch sclk or latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
    end
  end

endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: directed bench for shift_tx.
// Drives a 24-bit/CLK_DIV=2 instance and a 2-bit/CLK_DIV=1 instance, each
// feeding a model of an external shift-register chain (shift on sclk rise,
// store on latch rise), and compares against hand-computed values.
// With SHIFT_TX_AUTO_REFRESH_EN defined the refresh behaviour is exercised
// as well.
module tb_shift_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data_in;
  logic        valid;
  logic        ready;
  logic        sdo;
  logic        sclk;
  logic        latch;

  logic [1:0]  data_small;
  logic        valid_small;
  logic        ready_small;
  logic        sdo_small;
  logic        sclk_small;
  logic        latch_small;

  int errors = 0;
  int checks = 0;

  // Chain models
  logic [23:0] chain = '0;
  logic [23:0] latched = '0;
  int          rises = 0;
  int          latch_count = 0;
  logic [1:0]  chain_small = '0;
  logic [1:0]  latched_small = '0;
  int          rises_small = 0;

  int          n;
  int          base_rises;
  int          base_latch;
  int          base_rises_small;
  int          latch_cycles;
  logic [5:0]  sclk_trace;
  logic [5:0]  latch_trace;
  logic [5:0]  sdo_trace;
`ifdef SHIFT_TX_AUTO_REFRESH_EN
  int          latch_at [3];
  int          k;
  logic        prev_latch;
`endif

  always #5 clk = ~clk;

  shift_tx #(.WIDTH(24), .CLK_DIV(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_in),
    .valid  (valid),
    .ready  (ready),
    .sdo    (sdo),
    .sclk   (sclk),
    .latch  (latch)
  );

  shift_tx #(.WIDTH(2), .CLK_DIV(1)) dut_small (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_in(data_small),
    .valid  (valid_small),
    .ready  (ready_small),
    .sdo    (sdo_small),
    .sclk   (sclk_small),
    .latch  (latch_small)
  );

  always @(posedge sclk) begin
    chain <= {chain[22:0], sdo};
    rises <= rises + 1;
  end

  always @(posedge latch) begin
    latched     <= chain;
    latch_count <= latch_count + 1;
  end

  always @(posedge sclk_small) begin
    chain_small <= {chain_small[0], sdo_small};
    rises_small <= rises_small + 1;
  end

  always @(posedge latch_small) begin
    latched_small <= chain_small;
  end

  task automatic applyStimulus(input logic rst_val, input logic [23:0] word, input logic v);
    rst_n   = rst_val;
    data_in = word;
    valid   = v;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 24'h0, 1'b0);
    data_small  = 2'b00;
    valid_small = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_sdo",   64'(sdo),   64'd0);
    checkOutput("reset_sclk",  64'(sclk),  64'd0);
    checkOutput("reset_latch", 64'(latch), 64'd0);

    // Idle without a request: nothing happens
    applyStimulus(1'b1, 24'h0, 1'b0);
    base_rises = rises;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("idle_ready",   64'(ready), 64'd1);
    checkOutput("idle_no_sclk", 64'(rises - base_rises), 64'd0);

    // Basic frame
    $display("[TB] basic frame");
    base_rises   = rises;
    base_latch   = latch_count;
    latch_cycles = 0;
    applyStimulus(1'b1, 24'hA53C0F, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);
    n = 0;
    while (!ready && n < 1000) begin
      if (latch) latch_cycles++;
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("basic_len",        64'(n), 64'd100);
    checkOutput("basic_rises",      64'(rises - base_rises), 64'd24);
    checkOutput("basic_latches",    64'(latch_count - base_latch), 64'd1);
    checkOutput("basic_word",       64'(latched), 64'hA53C0F);
    checkOutput("basic_latch_high", 64'(latch_cycles), 64'd2);
    checkOutput("basic_sdo_hold",   64'(sdo), 64'd1);
    checkOutput("basic_idle_sclk",  64'(sclk), 64'd0);
    checkOutput("basic_idle_latch", 64'(latch), 64'd0);
    applyStimulus(1'b0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);

    // Request during SHIFT is ignored
    $display("[TB] ignored request");
    base_rises = rises;
    base_latch = latch_count;
    applyStimulus(1'b1, 24'h3CA55A, 1'b1);
    @(posedge clk);
    #1;
    n = 0;
    while (!ready && n < 1000) begin
      if (n == 20) applyStimulus(1'b1, 24'hFFFFFF, 1'b1);
      else         applyStimulus(1'b1, 24'h0, 1'b0);
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("ign_len",     64'(n), 64'd100);
    checkOutput("ign_word",    64'(latched), 64'h3CA55A);
    checkOutput("ign_latches", 64'(latch_count - base_latch), 64'd1);
    checkOutput("ign_rises",   64'(rises - base_rises), 64'd24);
`ifndef SHIFT_TX_AUTO_REFRESH_EN
    repeat (50) @(posedge clk);
    #1;
    checkOutput("ign_no_second_ready", 64'(ready), 64'd1);
    checkOutput("ign_no_second_rises", 64'(rises - base_rises), 64'd24);
`else
    n = 0;
    while (!latch && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("ign_refresh_word", 64'(latched), 64'h3CA55A);
`endif
    applyStimulus(1'b0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);

    // Back-to-back frames with valid held high
    $display("[TB] back-to-back");
    base_rises = rises;
    base_latch = latch_count;
    applyStimulus(1'b1, 24'h000001, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h800000, 1'b1);
    n = 0;
    while (!ready && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("b2b_len1",     64'(n), 64'd100);
    checkOutput("b2b_word1",    64'(latched), 64'h000001);
    checkOutput("b2b_latches1", 64'(latch_count - base_latch), 64'd1);
    checkOutput("b2b_rises1",   64'(rises - base_rises), 64'd24);
    @(posedge clk);
    #1;
    checkOutput("b2b_gap", 64'(ready), 64'd0);
    applyStimulus(1'b1, 24'h0, 1'b0);
    n = 0;
    while (!ready && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("b2b_len2",     64'(n), 64'd100);
    checkOutput("b2b_word2",    64'(latched), 64'h800000);
    checkOutput("b2b_latches2", 64'(latch_count - base_latch), 64'd2);
    checkOutput("b2b_rises2",   64'(rises - base_rises), 64'd48);
    applyStimulus(1'b0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);

    // Reset in the sclk-high half of bit 10
    $display("[TB] mid-frame reset");
    base_rises = rises;
    base_latch = latch_count;
    applyStimulus(1'b1, 24'hFFFFFF, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);
    repeat (42) @(posedge clk);
    #1;
    checkOutput("mid_pre_sclk", 64'(sclk), 64'd1);
    checkOutput("mid_pre_sdo",  64'(sdo),  64'd1);
    applyStimulus(1'b0, 24'h0, 1'b0);
    #1;
    checkOutput("mid_sclk",  64'(sclk),  64'd0);
    checkOutput("mid_latch", 64'(latch), 64'd0);
    checkOutput("mid_sdo",   64'(sdo),   64'd0);
    checkOutput("mid_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);
    repeat (150) @(posedge clk);
    #1;
    checkOutput("mid_no_latch", 64'(latch_count - base_latch), 64'd0);
    checkOutput("mid_rises",    64'(rises - base_rises), 64'd11);
    checkOutput("mid_idle",     64'(ready), 64'd1);

    // Minimal geometry: WIDTH=2, CLK_DIV=1
    $display("[TB] WIDTH=2 CLK_DIV=1");
    base_rises_small = rises_small;
    sclk_trace  = '0;
    latch_trace = '0;
    sdo_trace   = '0;
    data_small  = 2'b10;
    valid_small = 1'b1;
    @(posedge clk);
    #1;
    valid_small = 1'b0;
    data_small  = 2'b00;
    n = 0;
    while (!ready_small && n < 20) begin
      sclk_trace  = {sclk_trace[4:0], sclk_small};
      latch_trace = {latch_trace[4:0], latch_small};
      sdo_trace   = {sdo_trace[4:0], sdo_small};
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("small_len",   64'(n), 64'd6);
    checkOutput("small_sclk",  64'(sclk_trace),  64'b010100);
    checkOutput("small_latch", 64'(latch_trace), 64'b000010);
    checkOutput("small_sdo",   64'(sdo_trace),   64'b110000);
    checkOutput("small_word",  64'(latched_small), 64'b10);
    checkOutput("small_rises", 64'(rises_small - base_rises_small), 64'd2);

`ifdef SHIFT_TX_AUTO_REFRESH_EN
    // Auto refresh: one word, then valid low
    $display("[TB] auto refresh");
    applyStimulus(1'b0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    base_latch = latch_count;
    applyStimulus(1'b1, 24'h123456, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);
    n = 0;
    k = 0;
    prev_latch = 1'b0;
    while (k < 3 && n < 2000) begin
      if (latch && !prev_latch) begin
        latch_at[k] = n;
        k++;
      end
      prev_latch = latch;
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("ref_count",   64'(k), 64'd3);
    checkOutput("ref_period1", 64'(latch_at[1] - latch_at[0]), 64'd101);
    checkOutput("ref_period2", 64'(latch_at[2] - latch_at[1]), 64'd101);
    checkOutput("ref_word",    64'(latched), 64'h123456);
    checkOutput("ref_latches", 64'(latch_count - base_latch), 64'd3);
    n = 0;
    while (!ready && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b1, 24'h654321, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 24'h0, 1'b0);
    checkOutput("ref_busy", 64'(ready), 64'd0);
    n = 0;
    while (!latch && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    checkOutput("ref_new_word", 64'(latched), 64'h654321);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning number of bits per frame (legal 2..64).
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sclk half-period (legal 1..255).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port valid  input  1  request to send data_in.
REQ-007 SHALL have port ready  output  1  high when a new word can be accepted.
REQ-008 SHALL have port sdo  output  1  serial data to the external shift-register chain.
REQ-009 SHALL have port sclk  output  1  shift clock to the chain; the chain samples on its rising edge.
REQ-010 SHALL have port latch  output  1  storage strobe to the chain; outputs update on its rising edge.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, LATCH.
REQ-012 SHALL accept a word only when valid && ready at a clk edge, capturing data_in into a WIDTH-bit shift register and entering SHIFT on the next cycle.
REQ-013 SHALL drive ready high only in IDLE; valid outside IDLE SHALL be ignored (no queuing).
REQ-014 SHALL transmit MSB first; bit k occupies 2*CLK_DIV clk cycles: sclk low for the first CLK_DIV cycles, high for the next CLK_DIV.
REQ-015 SHALL present each bit on sdo in the first cycle of its bit period and hold it stable for the full period, giving CLK_DIV cycles of setup before the sclk rise.
REQ-016 SHALL leave SHIFT for LATCH after exactly WIDTH bit periods, with a bit counter that does not wrap within a frame.
REQ-017 SHALL hold latch high for the first CLK_DIV cycles of LATCH and low for the next CLK_DIV, with sclk low throughout, then return to IDLE.
REQ-018 SHALL make total frame length (accept cycle excluded) exactly (WIDTH+1)*2*CLK_DIV clk cycles.
REQ-019 SHALL hold sclk=0, latch=0 in IDLE, with sdo holding the last transmitted bit.
REQ-020 SHALL accept a new word in the first IDLE cycle after LATCH if valid is high (back-to-back frames, one IDLE cycle minimum gap).

Reset
REQ-021 SHALL, on rst_n low, asynchronously force state=IDLE, ready=1, sdo=0, sclk=0, latch=0, shift register=0, counters=0.
REQ-022 SHALL abort any frame in progress when reset mid-frame without issuing a latch pulse; the discarded word SHALL NOT be retransmitted.
REQ-023 SHALL leave reset deassertion without glitching sclk or latch.

Configuration
REQ-024 SHALL support macro SHIFT_TX_AUTO_REFRESH_EN.
REQ-025 SHALL, with SHIFT_TX_AUTO_REFRESH_EN defined, retain the last accepted word and, if no valid arrives in an IDLE cycle, start retransmitting it on the next cycle; ready SHALL stay high only in IDLE and a new valid SHALL take priority over refresh in the same cycle.
REQ-026 SHALL, without the macro, stay in IDLE indefinitely until valid, and SHALL NOT infer the retained-word register.

Structure
REQ-027 SHALL place the FSM state enum and the default values of WIDTH and CLK_DIV in shared package shift_tx_pkg.
REQ-028 SHALL instantiate one sub-module, sclk_tick_gen: a CLK_DIV half-period counter producing a one-cycle tick at each half-period boundary, cleared on frame start.

Verification
REQ-029 SHALL cover a basic frame: WIDTH=24, CLK_DIV=2, data_in=24'hA5_3C_0F -> sdo bits 1010_0101_0011_1100_0000_1111 on successive sclk rises, latch high 2 cycles, ready back after 100 cycles.
REQ-030 SHALL cover ignored request: valid pulsed with 24'hFFFFFF during SHIFT -> frame in flight unchanged, no second frame.
REQ-031 SHALL cover back-to-back: valid held high with 24'h000001 then 24'h800000 -> two frames, one IDLE cycle apart, each with exactly 24 sclk rises and one latch pulse.
REQ-032 SHALL cover mid-frame reset: rst_n low at bit 10 -> same cycle sclk=0, latch=0, sdo=0, ready=1; no latch pulse seen by the chain model.
REQ-033 SHALL cover CLK_DIV=1, WIDTH=2: data 2'b10 -> frame 6 cycles, sclk toggling every cycle.
REQ-034 SHALL cover, with SHIFT_TX_AUTO_REFRESH_EN, one word 24'h123456 then valid low -> identical frames repeat every 101 cycles; new valid 24'h654321 in IDLE -> next frame carries 24'h654321.
